wb_trace_buffer: RTL and testbench
==================================

// Module: wb_trace_buffer
// PURPOSE
//  Parametrised, synthesizable retirement-trace capture for the 5-stage pipeline CPU.
//  Records {WB pc, cycle stamp} for every retiring instruction into a circular buffer.
//  Supports continuous and one-shot capture, plus PC-match triggering with post-trigger depth.
//  Contents are read back by index, in the same way the register-file and memory debug ports are read.
// PARAMETERS
//  PC_W     32  width of captured PC
//  STAMP_W  16  width of free-running cycle stamp (wraps)
//  DEPTH    16  buffer entries; power of two, >=2
//  ADDR_W    4  log2(DEPTH)
// PORTS
//  clk        in   1         clock, all logic on rising edge
//  reset      in   1         synchronous, active-high
//  arm        in   1         pulse: clear buffer, start capture
//  mode       in   1         0 = continuous wrap, 1 = one-shot (stop when full)
//  trig_en    in   1         enable PC-match trigger
//  trig_pc    in   PC_W      trigger PC
//  post_cnt   in   ADDR_W    samples stored after trigger entry; sampled on trigger
//  wb_valid   in   1         instruction retires this cycle
//  wb_pc      in   PC_W      PC of retiring instruction
//  rd_idx     in   ADDR_W    read index; 0 = oldest stored entry
//  rd_pc      out  PC_W      PC at rd_idx (registered)
//  rd_stamp   out  STAMP_W   stamp at rd_idx (registered)
//  count      out  ADDR_W+1  entries held, saturates at DEPTH
//  state      out  2         0 IDLE, 1 RUN, 2 POST, 3 DONE
//  triggered  out  1         trigger matched since last arm
//  done       out  1         state==DONE
// BEHAVIOUR
//  Reset: state=IDLE; count, wr_ptr, stamp, triggered, done, rd_pc, rd_stamp = 0.
//    RAM contents are not cleared.
//  stamp: increments every cycle after reset, wraps at 2^STAMP_W.
//    Each stored entry carries the stamp value of its write cycle.
//  arm: highest priority in every state.
//    Next cycle: state=RUN, wr_ptr=0, count=0, triggered=0.
//    Any wb_valid in the arm cycle is dropped.
//  IDLE/DONE: no writes. Only arm leaves these states.
//  RUN: on wb_valid, write {wb_pc,stamp} at wr_ptr; wr_ptr+1 mod DEPTH; count+1, saturating at DEPTH.
//    mode=0: overwrite the oldest entry when full.
//    mode=1: the write that makes count==DEPTH moves state to DONE.
//  Trigger: in RUN with trig_en && wb_valid && wb_pc==trig_pc.
//    The matching entry is stored and triggered=1.
//    post_cnt==0 -> DONE; otherwise POST with remain=post_cnt.
//    Max post_cnt is DEPTH-1, so the trigger entry is always retained.
//  One-shot full and trigger in the same cycle: DONE wins; triggered still sets 1.
//  POST: each wb_valid stores an entry and decrements remain; remain reaches 0 -> DONE.
//    Always wraps, regardless of mode. Further matches are ignored.
//  Read: entry = (oldest + rd_idx) mod DEPTH, where oldest = (count<DEPTH) ? 0 : wr_ptr.
//    rd_pc/rd_stamp are valid 1 cycle after rd_idx is applied.
//    rd_idx >= count -> rd_pc=0, rd_stamp=0.
//  Read and write to the same slot in one cycle: read returns the old content.
//  mode and trig_en are sampled every cycle; changing them mid-capture takes effect next cycle.
//  Reset mid-capture: returns to IDLE in the next cycle; count=0, so every read returns 0.
// TESTING
//  1. Reset, arm, mode=0, 20 retirements pc=0x00..0x4C (step 4)
//     -> count=16; rd_idx 0 -> pc 0x10; rd_idx 15 -> pc 0x4C.
//  2. mode=1, arm, 20 retirements -> DONE after 16th; rd_idx 15 -> pc 0x3C;
//     later wb_valid ignored; count=16.
//  3. trig_en=1, trig_pc=0x20, post_cnt=3, retire 0x00.. step 4
//     -> triggered=1, DONE after pc 0x2C; newest entry 0x2C.
//  4. arm and wb_valid in the same cycle, then 2 retirements -> count=2; first entry is the post-arm pc.
//  5. 5 retirements with idle gaps -> rd_idx 5..15 read 0; stamps strictly increasing;
//     rd latency exactly 1 cycle.
//  6. reset asserted in POST -> next cycle state=0, count=0, triggered=0, rd_pc=0.

Source files
------------

// File: rtl/wb_trace_buffer.sv
// Retirement-trace capture: records {WB pc, cycle stamp} per retiring instruction
// into a circular buffer with continuous/one-shot modes and PC-match triggering.
module wb_trace_buffer #(
  parameter int PC_W    = 32,
  parameter int STAMP_W = 16,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic               mode,
  input  logic               trig_en,
  input  logic [PC_W-1:0]    trig_pc,
  input  logic [ADDR_W-1:0]  post_cnt,
  input  logic               wb_valid,
  input  logic [PC_W-1:0]    wb_pc,
  input  logic [ADDR_W-1:0]  rd_idx,
  output logic [PC_W-1:0]    rd_pc,
  output logic [STAMP_W-1:0] rd_stamp,
  output logic [ADDR_W:0]    count,
  output logic [1:0]         state,
  output logic               triggered,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  state_t               state_reg, state_next;
  logic [ADDR_W-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0]    remain_reg, remain_next;
  logic [ADDR_W:0]      count_reg, count_next;
  logic [STAMP_W-1:0]   stamp_reg;
  logic                 triggered_reg, triggered_next;
  logic                 wr_en;
  logic                 hit;

  logic [PC_W-1:0]      pc_mem    [DEPTH];
  logic [STAMP_W-1:0]   stamp_mem [DEPTH];
  logic [ADDR_W-1:0]    rd_addr;
  logic                 rd_ok, rd_ok_reg;
  logic [PC_W-1:0]      rd_pc_q;
  logic [STAMP_W-1:0]   rd_stamp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      wr_ptr_reg    <= '0;
      remain_reg    <= '0;
      count_reg     <= '0;
      stamp_reg     <= '0;
      triggered_reg <= 1'b0;
      rd_ok_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      remain_reg    <= remain_next;
      count_reg     <= count_next;
      stamp_reg     <= stamp_reg + STAMP_W'(1);
      triggered_reg <= triggered_next;
      rd_ok_reg     <= rd_ok;
    end
  end

  always_comb begin
    state_next     = state_reg;
    wr_ptr_next    = wr_ptr_reg;
    remain_next    = remain_reg;
    count_next     = count_reg;
    triggered_next = triggered_reg;
    wr_en          = 1'b0;
    hit            = trig_en && (wb_pc == trig_pc);
    if (arm) begin
      state_next     = ST_RUN;
      wr_ptr_next    = '0;
      count_next     = '0;
      triggered_next = 1'b0;
    end else if (wb_valid && (state_reg == ST_RUN || state_reg == ST_POST)) begin
      wr_en       = 1'b1;
      wr_ptr_next = wr_ptr_reg + 1'b1;
      if (count_reg != FULL) count_next = count_reg + 1'b1;
      if (state_reg == ST_RUN) begin
        if (hit) triggered_next = 1'b1;
        // A one-shot capture filling up takes precedence over entering POST.
        if (mode && count_next == FULL) begin
          state_next = ST_DONE;
        end else if (hit) begin
          remain_next = post_cnt;
          state_next  = (post_cnt == '0) ? ST_DONE : ST_POST;
        end
      end else begin
        remain_next = remain_reg - 1'b1;
        if (remain_reg == ADDR_W'(1)) state_next = ST_DONE;
      end
    end
  end

  // Once the buffer has wrapped, the oldest entry sits at the write pointer.
  assign rd_addr = ((count_reg == FULL) ? wr_ptr_reg : '0) + rd_idx;
  assign rd_ok   = ({1'b0, rd_idx} < count_reg);

  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      pc_mem[wr_ptr_reg]    <= wb_pc;
      stamp_mem[wr_ptr_reg] <= stamp_reg;
    end
    rd_pc_q    <= pc_mem[rd_addr];
    rd_stamp_q <= stamp_mem[rd_addr];
  end

  assign rd_pc     = rd_ok_reg ? rd_pc_q : '0;
  assign rd_stamp  = rd_ok_reg ? rd_stamp_q : '0;
  assign count     = count_reg;
  assign state     = state_reg;
  assign triggered = triggered_reg;
  assign done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench for wb_trace_buffer: a queue-based reference model predicts
// every read and status output; a negedge monitor pops and compares.
module tb_wb_trace_buffer;
  localparam int PC_W = 32, STAMP_W = 16, DEPTH = 16, ADDR_W = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_POST = 2, S_DONE = 3;

  logic               clk = 1'b0;
  logic               reset, arm, mode, trig_en, wb_valid;
  logic [PC_W-1:0]    trig_pc, wb_pc;
  logic [ADDR_W-1:0]  post_cnt, rd_idx;
  logic [PC_W-1:0]    rd_pc;
  logic [STAMP_W-1:0] rd_stamp;
  logic [ADDR_W:0]    count;
  logic [1:0]         state;
  logic               triggered, done;

  always #5 clk = ~clk;

  wb_trace_buffer #(.PC_W(PC_W), .STAMP_W(STAMP_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .arm(arm), .mode(mode), .trig_en(trig_en),
    .trig_pc(trig_pc), .post_cnt(post_cnt), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .rd_idx(rd_idx), .rd_pc(rd_pc), .rd_stamp(rd_stamp), .count(count),
    .state(state), .triggered(triggered), .done(done)
  );

  typedef struct { logic [31:0] pc; logic [15:0] stamp; int idx; } rd_exp_t;
  typedef struct { int cnt; int st; bit trig; } st_exp_t;

  rd_exp_t rdq[$];
  st_exp_t stq[$];
  int checks = 0, failures = 0;

  // Reference model: stored entries oldest-first, at most DEPTH of them.
  logic [31:0] m_pc[$];
  logic [15:0] m_st[$];
  int          m_state = S_IDLE;
  bit          m_trig = 1'b0;
  int          m_remain = 0;
  logic [15:0] m_stamp = '0;

  function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endfunction

  function automatic void m_store(logic [31:0] pc, logic [15:0] s);
    m_pc.push_back(pc);
    m_st.push_back(s);
    if (m_pc.size() > DEPTH) begin
      void'(m_pc.pop_front());
      void'(m_st.pop_front());
    end
  endfunction

  task automatic tick();
    rd_exp_t r;
    st_exp_t s;
    logic [15:0] ws;
    bit hit;
    @(posedge clk);
    r.idx = int'(rd_idx);
    if (!reset && r.idx < m_pc.size()) begin
      r.pc = m_pc[r.idx];
      r.stamp = m_st[r.idx];
    end else begin
      r.pc = '0;
      r.stamp = '0;
    end
    if (reset) begin
      m_state = S_IDLE; m_pc.delete(); m_st.delete(); m_trig = 1'b0; m_stamp = '0;
    end else begin
      ws = m_stamp;
      m_stamp = m_stamp + 16'd1;
      if (arm) begin
        m_state = S_RUN; m_pc.delete(); m_st.delete(); m_trig = 1'b0;
      end else if (wb_valid && m_state == S_RUN) begin
        hit = trig_en && (wb_pc == trig_pc);
        m_store(wb_pc, ws);
        if (hit) m_trig = 1'b1;
        if (mode && m_pc.size() == DEPTH) m_state = S_DONE;
        else if (hit) begin
          m_remain = int'(post_cnt);
          m_state = (m_remain == 0) ? S_DONE : S_POST;
        end
      end else if (wb_valid && m_state == S_POST) begin
        m_store(wb_pc, ws);
        m_remain--;
        if (m_remain == 0) m_state = S_DONE;
      end
    end
    s.cnt = m_pc.size();
    s.st = m_state;
    s.trig = m_trig;
    rdq.push_back(r);
    stq.push_back(s);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    rd_exp_t r;
    st_exp_t s;
    if (rdq.size() > 0) begin
      r = rdq.pop_front();
      chk($sformatf("rd_pc[idx=%0d]", r.idx), 64'(rd_pc), 64'(r.pc));
      chk($sformatf("rd_stamp[idx=%0d]", r.idx), 64'(rd_stamp), 64'(r.stamp));
    end
    if (stq.size() > 0) begin
      s = stq.pop_front();
      chk("count", 64'(count), 64'(s.cnt));
      chk("state", 64'(state), 64'(s.st));
      chk("triggered", 64'(triggered), 64'(s.trig));
      chk("done", 64'(done), 64'(s.st == S_DONE));
    end
  end

  task automatic cyc(input bit v, input logic [31:0] pc, input int ri);
    wb_valid = v;
    wb_pc = pc;
    rd_idx = (ri < 0) ? 4'($urandom_range(0, 15)) : 4'(ri);
    tick();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    cyc(1'b0, 32'h0, -1);
    arm = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; arm = 1'b0; mode = 1'b0; trig_en = 1'b0; trig_pc = '0;
    post_cnt = '0; wb_valid = 1'b0; wb_pc = '0; rd_idx = '0;
    cyc(1'b0, 32'h0, 0);
    cyc(1'b0, 32'h0, 3);
    reset = 1'b0;
    $display("reset: count=%0d state=%0d", count, state);

    // 1: continuous wrap
    mode = 1'b0; do_arm();
    for (int i = 0; i < 20; i++) cyc(1'b1, 32'(i * 4), -1);
    cyc(1'b0, 0, 0); cyc(1'b0, 0, 15); cyc(1'b0, 0, 7);
    $display("test1 continuous: count=%0d rd_pc=%0h", count, rd_pc);

    // 2: one-shot
    mode = 1'b1; do_arm();
    for (int i = 0; i < 20; i++) cyc(1'b1, 32'(i * 4), -1);
    cyc(1'b0, 0, 15); cyc(1'b0, 0, 0);
    $display("test2 one-shot: count=%0d state=%0d rd_pc=%0h", count, state, rd_pc);

    // 3: PC trigger with post-trigger depth
    mode = 1'b0; trig_en = 1'b1; trig_pc = 32'h20; post_cnt = 4'd3; do_arm();
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'(i * 4), -1);
    cyc(1'b0, 0, 11); cyc(1'b0, 0, 12);
    $display("test3 trigger: triggered=%0d state=%0d count=%0d", triggered, state, count);

    // 4: arm coincident with a retirement
    trig_en = 1'b0; arm = 1'b1; cyc(1'b1, 32'h100, -1); arm = 1'b0;
    cyc(1'b1, 32'h104, 0); cyc(1'b1, 32'h108, 0);
    cyc(1'b0, 0, 0); cyc(1'b0, 0, 1); cyc(1'b0, 0, 2);
    $display("test4 arm+valid: count=%0d", count);

    // 5: sparse retirements, reads beyond count, stamp ordering
    do_arm();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 32'(32'h200 + i * 4), -1);
      for (int g = 0; g <= i; g++) cyc(1'b0, 0, -1);
    end
    for (int k = 0; k < 16; k++) cyc(1'b0, 0, k);
    $display("test5 gaps: count=%0d", count);

    // 6: reset during POST
    trig_en = 1'b1; trig_pc = 32'h308; post_cnt = 4'd5; do_arm();
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'(32'h300 + i * 4), 0);
    reset = 1'b1; cyc(1'b0, 0, 0); reset = 1'b0;
    cyc(1'b0, 0, 0); cyc(1'b0, 0, 1);
    $display("test6 reset in POST: state=%0d count=%0d triggered=%0d", state, count, triggered);

    // Randomised captures
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      arm = !reset && ($urandom_range(0, 39) == 0);
      if (arm) begin
        mode = 1'($urandom_range(0, 1));
        trig_en = 1'($urandom_range(0, 1));
        trig_pc = 32'(4 * $urandom_range(0, 31));
        post_cnt = 4'($urandom_range(0, 15));
        $display("random arm n=%0d mode=%0d trig_en=%0d trig_pc=%0h post_cnt=%0d",
                 n, mode, trig_en, trig_pc, post_cnt);
      end
      if ($urandom_range(0, 49) == 0) trig_en = ~trig_en;
      cyc($urandom_range(0, 9) < 7, 32'(4 * $urandom_range(0, 31)), -1);
    end
    reset = 1'b0; arm = 1'b0; wb_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drain", 64'(rdq.size() + stq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
